// File: rtl/scrambler_block_sequencer_if.sv
// scrambler_block_sequencer_if: PIPE receive beats in, registered stream plus descrambler framing controls out.
interface scrambler_block_sequencer_if #(parameter int DATA_W = 32);
  logic [2:0]          GEN;
  logic [5:0]          PIPEWIDTH;
  logic                rxValid;
  logic                rxStartBlock;
  logic [1:0]          rxSyncHeader;
  logic [DATA_W-1:0]   rxData;
  logic [DATA_W/8-1:0] rxDataK;
  logic                ltssmScrambleOff;
  logic [DATA_W-1:0]   masterData;
  logic [DATA_W/8-1:0] masterDataK;
  logic                masterValid;
  logic [1:0]          syncHeader;
  logic                turnOff;
  logic                blockStart;
  logic [3:0]          symIdx;
  logic                blockErr;
  logic [15:0]         blockCount;
  logic [7:0]          errCount;
  modport master (
    output GEN, PIPEWIDTH, rxValid, rxStartBlock, rxSyncHeader, rxData, rxDataK, ltssmScrambleOff,
    input  masterData, masterDataK, masterValid, syncHeader, turnOff, blockStart, symIdx, blockErr,
           blockCount, errCount
  );
  modport slave (
    input  GEN, PIPEWIDTH, rxValid, rxStartBlock, rxSyncHeader, rxData, rxDataK, ltssmScrambleOff,
    output masterData, masterDataK, masterValid, syncHeader, turnOff, blockStart, symIdx, blockErr,
           blockCount, errCount
  );
endinterface

// File: rtl/scrambler_block_sequencer.sv
// scrambler_block_sequencer: 128b/130b block framing tracker with 1-cycle aligned data path.
// Optional block/error statistics counters are enabled by defining SEQ_BLOCK_STATS_EN.
module scrambler_block_sequencer #(
  parameter int SYMS_PER_BLOCK = 16
) (
  input logic clk,
  input logic reset_n,
  scrambler_block_sequencer_if.slave bus
);
  localparam int CW = $clog2(SYMS_PER_BLOCK) + 1;
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
  state_t        state;
  logic [CW-1:0] cnt, bpb, base, nxt;
  logic [2:0]    gen_q;
  logic [5:0]    pw_q;
  logic          g3, cfg_chg, act, start, bad_hdr, miss, err, adv, wrap;
  always_comb begin
    g3      = bus.GEN >= 3'd3;
    bpb     = (bus.PIPEWIDTH == 6'd8) ? CW'(1) : (bus.PIPEWIDTH == 6'd16) ? CW'(2) : CW'(4);
    cfg_chg = (bus.GEN != gen_q) || (bus.PIPEWIDTH != pw_q);
    act     = g3 && bus.rxValid && !cfg_chg;
    start   = act && bus.rxStartBlock;
    bad_hdr = (bus.rxSyncHeader == 2'b00) || (bus.rxSyncHeader == 2'b11);
    miss    = act && !bus.rxStartBlock && (state == HDR);
    // resync and bad header on the same beat collapse into one pulse
    err     = (start && (bad_hdr || (state == BODY && cnt != '0))) || miss;
    adv     = start || (act && state == BODY);
    base    = start ? '0 : cnt;
    nxt     = base + bpb;
    wrap    = nxt == CW'(SYMS_PER_BLOCK);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      gen_q           <= '0;
      pw_q            <= '0;
      bus.masterData  <= '0;
      bus.masterDataK <= '0;
      bus.masterValid <= 1'b0;
      bus.syncHeader  <= 2'b00;
      bus.turnOff     <= 1'b1;
      bus.blockStart  <= 1'b0;
      bus.symIdx      <= '0;
      bus.blockErr    <= 1'b0;
    end else begin
      gen_q           <= bus.GEN;
      pw_q            <= bus.PIPEWIDTH;
      bus.masterValid <= bus.rxValid;
      if (bus.rxValid) begin
        bus.masterData  <= bus.rxData;
        bus.masterDataK <= bus.rxDataK;
      end
      bus.blockErr   <= err;
      bus.blockStart <= start;
      bus.syncHeader <= !start ? 2'b00 : bad_hdr ? 2'b10 : bus.rxSyncHeader;
      bus.turnOff    <= (!g3 || start) ? bus.ltssmScrambleOff : bus.turnOff;
      bus.symIdx     <= (!g3 || cfg_chg) ? '0 : !bus.rxValid ? bus.symIdx :
                        (state == BODY && !start) ? cnt[3:0] : '0;
      if (!g3 || cfg_chg || miss) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (adv) begin
        state <= wrap ? HDR : BODY;
        cnt   <= wrap ? '0 : nxt;
      end
    end
  end
`ifdef SEQ_BLOCK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.blockCount <= '0;
      bus.errCount   <= '0;
    end else begin
      if (start) bus.blockCount <= bus.blockCount + 16'd1;
      if (err && bus.errCount != 8'hFF) bus.errCount <= bus.errCount + 8'd1;
    end
  end
`else
  assign bus.blockCount = '0;
  assign bus.errCount   = '0;
`endif
endmodule

// File: tb/tb_scrambler_block_sequencer.sv
// tb_scrambler_block_sequencer: directed scoreboard bench for the block sequencer.
module tb_scrambler_block_sequencer;
  typedef struct {
    logic        v;
    logic [31:0] data;
    logic [3:0]  k;
    logic [1:0]  sh;
    logic        bs;
    logic [3:0]  idx;
    logic        err;
    logic        toff;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];
  logic [31:0] last_data = '0;
  logic [3:0]  last_k = '0;
  scrambler_block_sequencer_if #(.DATA_W(32)) bus ();
  scrambler_block_sequencer #(.SYMS_PER_BLOCK(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic v, input logic sb, input logic [1:0] hdr, input logic off,
                      input logic [1:0] e_sh, input logic e_bs, input logic [3:0] e_idx,
                      input logic e_err, input logic e_toff);
    exp_t e, o;
    logic [31:0] d;
    logic [3:0]  k;
    d = $urandom;
    k = 4'($urandom);
    bus.rxValid = v;
    bus.rxStartBlock = sb;
    bus.rxSyncHeader = hdr;
    bus.rxData = d;
    bus.rxDataK = k;
    bus.ltssmScrambleOff = off;
    if (v) begin
      last_data = d;
      last_k = k;
    end
    e = '{v, last_data, last_k, e_sh, e_bs, e_idx, e_err, e_toff};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("masterValid", 32'(bus.masterValid), 32'(o.v));
    chk("masterData", bus.masterData, o.data);
    chk("masterDataK", 32'(bus.masterDataK), 32'(o.k));
    chk("syncHeader", 32'(bus.syncHeader), 32'(o.sh));
    chk("blockStart", 32'(bus.blockStart), 32'(o.bs));
    chk("symIdx", 32'(bus.symIdx), 32'(o.idx));
    chk("blockErr", 32'(bus.blockErr), 32'(o.err));
    chk("turnOff", 32'(bus.turnOff), 32'(o.toff));
  endtask
  initial begin
    bus.GEN = 3'd3;
    bus.PIPEWIDTH = 6'd32;
    bus.rxValid = 1'b0;
    bus.rxStartBlock = 1'b0;
    bus.rxSyncHeader = 2'b00;
    bus.rxData = '0;
    bus.rxDataK = '0;
    bus.ltssmScrambleOff = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_turnOff", 32'(bus.turnOff), 32'd1);
    chk("rst_masterValid", 32'(bus.masterValid), 32'd0);
    chk("rst_masterData", bus.masterData, 32'd0);
    chk("rst_syncHeader", 32'(bus.syncHeader), 32'd0);
    chk("rst_symIdx", 32'(bus.symIdx), 32'd0);
    chk("rst_blockErr", 32'(bus.blockErr), 32'd0);
    reset_n = 1'b1;
    beat(0, 0, 2'b00, 0, 2'b00, 0, 4'd0, 0, 1);
    // GEN3 x32: three 4-beat blocks, header 01
    for (int b = 0; b < 12; b++)
      beat(1, b % 4 == 0, 2'b01, 0, (b % 4 == 0) ? 2'b01 : 2'b00, b % 4 == 0, 4'((b % 4) * 4), 0, 0);
    // turnOff latched only on block-start beats
    beat(1, 1, 2'b01, 1, 2'b01, 1, 4'd0, 0, 1);
    for (int b = 1; b < 4; b++) beat(1, 0, 2'b01, 0, 2'b00, 0, 4'(b * 4), 0, 1);
    beat(1, 1, 2'b01, 0, 2'b01, 1, 4'd0, 0, 0);
    for (int b = 1; b < 4; b++) beat(1, 0, 2'b01, 0, 2'b00, 0, 4'(b * 4), 0, 0);
    // GEN3 x8: 16 beats with a stall, then missing start
    bus.PIPEWIDTH = 6'd8;
    beat(0, 0, 2'b00, 0, 2'b00, 0, 4'd0, 0, 0);
    for (int b = 0; b < 16; b++) begin
      beat(1, b == 0, 2'b10, 0, (b == 0) ? 2'b10 : 2'b00, b == 0, 4'(b), 0, 0);
      if (b == 4) beat(0, 0, 2'b00, 0, 2'b00, 0, 4'd4, 0, 0);
    end
    beat(1, 0, 2'b10, 0, 2'b00, 0, 4'd0, 1, 0);
    beat(1, 0, 2'b10, 0, 2'b00, 0, 4'd0, 0, 0);
    // GEN3 x16: resync at counter 6, then bad header plus resync
    bus.PIPEWIDTH = 6'd16;
    beat(0, 0, 2'b00, 0, 2'b00, 0, 4'd0, 0, 0);
    for (int b = 0; b < 3; b++) beat(1, b == 0, 2'b01, 0, (b == 0) ? 2'b01 : 2'b00, b == 0, 4'(b * 2), 0, 0);
    beat(1, 1, 2'b01, 0, 2'b01, 1, 4'd0, 1, 0);
    for (int b = 1; b < 8; b++) beat(1, 0, 2'b01, 0, 2'b00, 0, 4'(b * 2), 0, 0);
    beat(1, 1, 2'b01, 0, 2'b01, 1, 4'd0, 0, 0);
    beat(1, 0, 2'b01, 0, 2'b00, 0, 4'd2, 0, 0);
    beat(1, 1, 2'b11, 0, 2'b10, 1, 4'd0, 1, 0);
    for (int b = 1; b < 8; b++) beat(1, 0, 2'b01, 0, 2'b00, 0, 4'(b * 2), 0, 0);
    // GEN2: framing bypassed, turnOff follows request
    bus.GEN = 3'd2;
    beat(1, 1, 2'b11, 1, 2'b00, 0, 4'd0, 0, 1);
    beat(1, 1, 2'b11, 0, 2'b00, 0, 4'd0, 0, 0);
    beat(1, 0, 2'b01, 1, 2'b00, 0, 4'd0, 0, 1);
    beat(1, 1, 2'b01, 0, 2'b00, 0, 4'd0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("async_turnOff", 32'(bus.turnOff), 32'd1);
    chk("async_masterValid", 32'(bus.masterValid), 32'd0);
    chk("async_masterData", bus.masterData, 32'd0);
    last_data = '0;
    last_k = '0;
    bus.GEN = 3'd3;
    bus.PIPEWIDTH = 6'd32;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    beat(0, 0, 2'b00, 0, 2'b00, 0, 4'd0, 0, 1);
    beat(1, 0, 2'b01, 0, 2'b00, 0, 4'd0, 0, 1);
    // three good blocks and one with header 11
    for (int b = 0; b < 16; b++)
      beat(1, b % 4 == 0, (b / 4 == 3) ? 2'b11 : 2'b01, 0,
           (b % 4 != 0) ? 2'b00 : (b / 4 == 3) ? 2'b10 : 2'b01,
           b % 4 == 0, 4'((b % 4) * 4), (b == 12), 0);
`ifdef SEQ_BLOCK_STATS_EN
    chk("blockCount", 32'(bus.blockCount), 32'd4);
    chk("errCount", 32'(bus.errCount), 32'd1);
`else
    chk("blockCount", 32'(bus.blockCount), 32'd0);
    chk("errCount", 32'(bus.errCount), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
